// File: rtl/eth_pcs_params.sv
// Shared 10GBASE-R receive PCS constants: sync header encodings and
// block-lock window thresholds with their counter widths.
package eth_pcs_params;

    localparam int unsigned W_SYNC = 2;

    localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
    localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

    localparam int unsigned SH_TH       = 64;
    localparam int unsigned SH_INVAL_TH = 16;
    localparam int unsigned SLIP_WAIT   = 2;

    localparam int unsigned SH_CNT_W       = $clog2(SH_TH) + 1;
    localparam int unsigned SH_INVAL_CNT_W = $clog2(SH_INVAL_TH) + 1;

endpackage

// File: rtl/eth_pcs_rx_block_sync.sv
// Receive block-lock state machine: tests sync headers in fixed windows,
// asserts lock after a clean window and commands gearbox slips on errors.
module eth_pcs_rx_block_sync #(
    parameter int unsigned SH_TH       = eth_pcs_params::SH_TH,
    parameter int unsigned SH_INVAL_TH = eth_pcs_params::SH_INVAL_TH,
    parameter int unsigned SLIP_WAIT   = eth_pcs_params::SLIP_WAIT
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_signal_ok,
    input  logic                              i_sh_valid,
    input  logic [eth_pcs_params::W_SYNC-1:0] i_sync,
    output logic                              o_slip,
    output logic                              o_block_lock,
    output logic                              o_sh_invalid
);
    import eth_pcs_params::*;

    localparam int unsigned SH_W   = $clog2(SH_TH) + 1;
    localparam int unsigned INV_W  = $clog2(SH_INVAL_TH) + 1;
    localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1) + 1;

    typedef enum logic [1:0] {
        LOCK_INIT,
        TEST_SH,
        SLIP_WAIT_ST
    } state_t;

    state_t             state;
    logic [SH_W-1:0]    sh_cnt;
    logic [INV_W-1:0]   sh_inval_cnt;
    logic [WAIT_W-1:0]  wait_cnt;

    logic               hdr_valid;
    logic [SH_W-1:0]    sh_cnt_inc;
    logic [INV_W-1:0]   inval_cnt_inc;
    logic [WAIT_W-1:0]  wait_inc;
    logic               window_done;
    logic               inval_done;

    // Header classification and the counter values this strobe would produce
    always_comb begin
        hdr_valid     = (i_sync == SYNC_DATA) || (i_sync == SYNC_CTRL);
        sh_cnt_inc    = sh_cnt + SH_W'(1);
        inval_cnt_inc = sh_inval_cnt + INV_W'(!hdr_valid);
        wait_inc      = wait_cnt + WAIT_W'(1);
        window_done   = (sh_cnt_inc == SH_W'(SH_TH));
        inval_done    = (inval_cnt_inc == INV_W'(SH_INVAL_TH));
    end

    always_ff @(posedge i_clk) begin
        o_slip       <= 1'b0;
        o_sh_invalid <= 1'b0;
        if (i_rst || !i_signal_ok) begin
            state        <= LOCK_INIT;
            sh_cnt       <= '0;
            sh_inval_cnt <= '0;
            wait_cnt     <= '0;
            o_block_lock <= 1'b0;
        end else begin
            unique case (state)
                LOCK_INIT: begin
                    sh_cnt       <= '0;
                    sh_inval_cnt <= '0;
                    wait_cnt     <= '0;
                    o_block_lock <= 1'b0;
                    state        <= TEST_SH;
                end
                TEST_SH: begin
                    if (i_sh_valid) begin
                        if (!hdr_valid) begin
                            o_sh_invalid <= 1'b1;
                            // Loss of lock wins over a window ending on the same strobe
                            if (!o_block_lock || inval_done) begin
                                o_block_lock <= 1'b0;
                                o_slip       <= 1'b1;
                                sh_cnt       <= '0;
                                sh_inval_cnt <= '0;
                                wait_cnt     <= '0;
                                state        <= SLIP_WAIT_ST;
                            end else if (window_done) begin
                                sh_cnt       <= '0;
                                sh_inval_cnt <= '0;
                            end else begin
                                sh_cnt       <= sh_cnt_inc;
                                sh_inval_cnt <= inval_cnt_inc;
                            end
                        end else if (window_done) begin
                            if (sh_inval_cnt == '0) begin
                                o_block_lock <= 1'b1;
                            end
                            sh_cnt       <= '0;
                            sh_inval_cnt <= '0;
                        end else begin
                            sh_cnt <= sh_cnt_inc;
                        end
                    end
                end
                SLIP_WAIT_ST: begin
                    // Let the gearbox settle on the new alignment before testing again
                    if (SLIP_WAIT == 0) begin
                        state <= TEST_SH;
                    end else if (i_sh_valid) begin
                        if (wait_inc == WAIT_W'(SLIP_WAIT)) begin
                            wait_cnt <= '0;
                            state    <= TEST_SH;
                        end else begin
                            wait_cnt <= wait_inc;
                        end
                    end
                end
                default: begin
                    state <= LOCK_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_pcs_rx_block_sync.sv
// Randomized self-checking bench for eth_pcs_rx_block_sync against a
// strobe-level behavioural model of the block-lock rules.
module tb_eth_pcs_rx_block_sync;

    localparam int unsigned WS = eth_pcs_params::W_SYNC;
    localparam logic [WS-1:0] SD = eth_pcs_params::SYNC_DATA;
    localparam logic [WS-1:0] SC = eth_pcs_params::SYNC_CTRL;

    logic          i_clk       = 1'b0;
    logic          i_rst       = 1'b1;
    logic          i_signal_ok = 1'b1;
    logic          i_sh_valid  = 1'b0;
    logic [WS-1:0] i_sync      = '0;
    logic          o_slip;
    logic          o_block_lock;
    logic          o_sh_invalid;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: window bookkeeping in plain integers
    bit m_init   = 1'b1;
    int m_tested = 0;
    int m_bad    = 0;
    int m_skip   = 0;
    bit e_lock   = 1'b0;
    bit e_slip   = 1'b0;
    bit e_inv    = 1'b0;

    eth_pcs_rx_block_sync dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_signal_ok  (i_signal_ok),
        .i_sh_valid   (i_sh_valid),
        .i_sync       (i_sync),
        .o_slip       (o_slip),
        .o_block_lock (o_block_lock),
        .o_sh_invalid (o_sh_invalid)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [WS-1:0] rand_good();
        return ($urandom_range(0, 1) == 0) ? SD : SC;
    endfunction

    function automatic logic [WS-1:0] rand_bad();
        return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    endfunction

    task automatic model_step(input bit rst, input bit ok, input bit sv, input logic [WS-1:0] sync);
        bit good;
        e_slip = 1'b0;
        e_inv  = 1'b0;
        good   = (sync == SD) || (sync == SC);
        if (rst || !ok) begin
            m_init = 1'b1; m_tested = 0; m_bad = 0; m_skip = 0; e_lock = 1'b0;
        end else if (m_init) begin
            m_init = 1'b0;
        end else if (sv) begin
            if (m_skip > 0) begin
                m_skip--;
            end else begin
                m_tested++;
                if (!good) begin
                    m_bad++;
                    e_inv = 1'b1;
                end
                if (!good && (!e_lock || m_bad == 16)) begin
                    e_lock = 1'b0; e_slip = 1'b1;
                    m_tested = 0; m_bad = 0; m_skip = 2;
                end else if (m_tested == 64) begin
                    if (m_bad == 0) e_lock = 1'b1;
                    m_tested = 0; m_bad = 0;
                end
            end
        end
    endtask

    // One clock: apply inputs, advance the model at the edge, settle past it
    task automatic cycle(input bit rst, input bit ok, input bit sv, input logic [WS-1:0] sync);
        i_rst = rst; i_signal_ok = ok; i_sh_valid = sv; i_sync = sync;
        @(posedge i_clk);
        model_step(rst, ok, sv, sync);
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), rand_bad());
        cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), rand_good());
        cycle(1'b0, 1'b1, 1'b0, SD);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, (i % 2 == 0) ? rand_bad() : SD);
            n_checks++;
            if ({o_block_lock, o_slip, o_sh_invalid} !== 3'b000)
                $display("FAIL reset_outputs cyc %0d: lock/slip/inv=%b want 000", i, {o_block_lock, o_slip, o_sh_invalid});
            else n_pass++;
        end
    endtask

    task automatic test_clean_lock();
        cycle(1'b0, 1'b1, 1'b0, SD);
        cycle(1'b0, 1'b1, 1'b0, SD);
        for (int i = 1; i <= 64; i++) begin
            cycle(1'b0, 1'b1, 1'b1, SD);
            n_checks++;
            if ({o_block_lock, o_slip, o_sh_invalid} !== {(i == 64), 2'b00})
                $display("FAIL clean_lock strobe %0d: lock/slip/inv=%b want %b", i, {o_block_lock, o_slip, o_sh_invalid}, {(i == 64), 2'b00});
            else n_pass++;
        end
    endtask

    task automatic test_slip_unlocked();
        int slips;
        slips = 0;
        do_reset();
        for (int i = 1; i <= 12 + 64; i++) begin
            logic [WS-1:0] s;
            bit want_lock;
            if (i == 10 || i == 11 || i == 12) s = rand_bad();
            else s = rand_good();
            cycle(1'b0, 1'b1, 1'b1, s);
            slips += int'(o_slip);
            want_lock = (i == 12 + 64);
            n_checks++;
            if ({o_block_lock, o_slip, o_sh_invalid} !== {want_lock, (i == 10), (i == 10)})
                $display("FAIL slip_unlocked strobe %0d: lock/slip/inv=%b want %b", i, {o_block_lock, o_slip, o_sh_invalid}, {want_lock, (i == 10), (i == 10)});
            else n_pass++;
            n_checks++;
            if ({o_block_lock, o_slip, o_sh_invalid} !== {e_lock, e_slip, e_inv})
                $display("FAIL slip_unlocked_model strobe %0d: lock/slip/inv=%b want %b", i, {o_block_lock, o_slip, o_sh_invalid}, {e_lock, e_slip, e_inv});
            else n_pass++;
        end
        n_checks++;
        if (slips != 1) $display("FAIL slip_unlocked_count: slips=%0d want 1", slips);
        else n_pass++;
    endtask

    task automatic test_locked_ber();
        bit bad_pos [64];
        int inv_pulses;
        int bads;
        for (int i = 0; i < 64; i++) bad_pos[i] = (i < 15);
        for (int i = 63; i > 0; i--) begin
            int j;
            bit t;
            j = int'($urandom_range(0, i));
            t = bad_pos[i]; bad_pos[i] = bad_pos[j]; bad_pos[j] = t;
        end
        inv_pulses = 0;
        for (int i = 0; i < 64; i++) begin
            cycle(1'b0, 1'b1, 1'b1, bad_pos[i] ? rand_bad() : rand_good());
            inv_pulses += int'(o_sh_invalid);
            n_checks++;
            if ({o_block_lock, o_slip} !== 2'b10)
                $display("FAIL ber_hold strobe %0d: lock/slip=%b want 10", i, {o_block_lock, o_slip});
            else n_pass++;
        end
        n_checks++;
        if (inv_pulses != 15) $display("FAIL ber_inv_count: pulses=%0d want 15", inv_pulses);
        else n_pass++;
        bads = 0;
        while (bads < 16) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'b1, 1'b1, rand_good());
            cycle(1'b0, 1'b1, 1'b1, rand_bad());
            bads++;
            n_checks++;
            if ({o_block_lock, o_slip, o_sh_invalid} !== {(bads < 16), (bads == 16), 1'b1})
                $display("FAIL ber_loss bad %0d: lock/slip/inv=%b want %b", bads, {o_block_lock, o_slip, o_sh_invalid}, {(bads < 16), (bads == 16), 1'b1});
            else n_pass++;
        end
    endtask

    task automatic test_signal_ok();
        do_reset();
        for (int i = 0; i < 64 + 20; i++) cycle(1'b0, 1'b1, 1'b1, rand_good());
        n_checks++;
        if (o_block_lock !== 1'b1) $display("FAIL sigok_prelock: lock=%b want 1", o_block_lock);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, rand_bad());
        n_checks++;
        if ({o_block_lock, o_slip, o_sh_invalid} !== 3'b000)
            $display("FAIL sigok_drop: lock/slip/inv=%b want 000", {o_block_lock, o_slip, o_sh_invalid});
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b0, SD);
        for (int i = 1; i <= 64; i++) begin
            cycle(1'b0, 1'b1, 1'b1, rand_good());
            n_checks++;
            if (o_block_lock !== (i == 64))
                $display("FAIL sigok_relock strobe %0d: lock=%b want %b", i, o_block_lock, (i == 64));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b1, rand_good());
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 1'b1, rand_bad());
            n_checks++;
            if ({o_block_lock, o_slip, o_sh_invalid} !== 3'b000)
                $display("FAIL rst_mid_window cyc %0d: lock/slip/inv=%b want 000", i, {o_block_lock, o_slip, o_sh_invalid});
            else n_pass++;
        end
        cycle(1'b0, 1'b1, 1'b0, SD);
        for (int i = 1; i <= 64; i++) begin
            cycle(1'b0, 1'b1, 1'b1, rand_good());
            n_checks++;
            if (o_block_lock !== (i == 64))
                $display("FAIL rst_mid_window_relock strobe %0d: lock=%b want %b", i, o_block_lock, (i == 64));
            else n_pass++;
        end
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, rand_good());
        cycle(1'b0, 1'b1, 1'b1, rand_bad());
        cycle(1'b0, 1'b1, 1'b1, rand_good());
        cycle(1'b1, 1'b1, 1'b1, rand_good());
        n_checks++;
        if ({o_block_lock, o_slip, o_sh_invalid} !== 3'b000)
            $display("FAIL rst_mid_wait: lock/slip/inv=%b want 000", {o_block_lock, o_slip, o_sh_invalid});
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b0, SD);
        for (int i = 1; i <= 64; i++) begin
            cycle(1'b0, 1'b1, 1'b1, rand_good());
            n_checks++;
            if (o_block_lock !== (i == 64))
                $display("FAIL rst_mid_wait_relock strobe %0d: lock=%b want %b", i, o_block_lock, (i == 64));
            else n_pass++;
        end
    endtask

    task automatic test_gaps();
        int strobes;
        int cyc;
        strobes = 0;
        cyc = 0;
        do_reset();
        while (strobes < 64 && cyc < 1000) begin
            bit sv;
            sv = ($urandom_range(0, 3) != 0);
            cycle(1'b0, 1'b1, sv, rand_good());
            cyc++;
            if (sv) strobes++;
            n_checks++;
            if ({o_block_lock, o_slip, o_sh_invalid} !== {(strobes == 64 && sv), 2'b00})
                $display("FAIL gaps cyc %0d strobes %0d: lock/slip/inv=%b want %b", cyc, strobes, {o_block_lock, o_slip, o_sh_invalid}, {(strobes == 64 && sv), 2'b00});
            else n_pass++;
        end
        n_checks++;
        if (strobes != 64) $display("FAIL gaps_budget: strobes=%0d want 64", strobes);
        else n_pass++;
    endtask

    task automatic test_random();
        bit prev_slip;
        prev_slip = 1'b0;
        do_reset();
        for (int i = 0; i < 5000; i++) begin
            bit rst, ok, sv;
            int bad_div;
            bad_div = (i < 2500) ? 300 : 14;
            rst = ($urandom_range(0, 699) == 0);
            ok  = ($urandom_range(0, 399) != 0);
            sv  = ($urandom_range(0, 3) != 0);
            cycle(rst, ok, sv, ($urandom_range(0, bad_div - 1) == 0) ? rand_bad() : rand_good());
            n_checks++;
            if ({o_block_lock, o_slip, o_sh_invalid} !== {e_lock, e_slip, e_inv})
                $display("FAIL random_model cyc %0d: lock/slip/inv=%b want %b", i, {o_block_lock, o_slip, o_sh_invalid}, {e_lock, e_slip, e_inv});
            else n_pass++;
            if (o_slip === 1'b1) begin
                n_checks++;
                if (prev_slip) $display("FAIL random_slip_back_to_back cyc %0d: slip=1 after slip=1 want 0", i);
                else n_pass++;
            end
            prev_slip = (o_slip === 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_slip_unlocked();
        test_locked_ber();
        test_signal_ok();
        test_reset_mid();
        test_gaps();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
